// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: turns single requests on a valid/ready request channel into one
// access on the simple CPU register bus. It samples read data after a fixed latency and
// returns a response on a valid/ready response channel. Only one request is outstanding
// at a time.
//
// Optional feature, enabled by defining CPU_BUS_BRIDGE_ADDR_CHK_EN:
//   An address above ADDR_MAX is accepted but never reaches the bus. It is answered
//   with resp_err = 1 and resp_rdata = 32'hDEAD_BEEF. Without the macro resp_err is
//   always 0 and ADDR_MAX has no effect.
//
// Ports:
//   clks, reset              block clock; asynchronous active-high reset
//   req_vld/req_rdy          request handshake
//   req_wr                   1 = write, 0 = read
//   req_addr, req_wdata      request address and write data
//   resp_vld/resp_rdy        response handshake
//   resp_rdata, resp_err     read data (0 for writes) and address error flag
//   cpu_addr, cpu_wdata      bus address and write data, held from accept to next accept
//   cpu_wr                   one-cycle write strobe
//   cpu_rd                   read-in-progress qualifier
//   cpu_rdata                wired read data from the register instances
module cpu_bus_bridge #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           RD_LAT     = 2,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = 16'hFFFF
) (
  input  logic                  clks,
  input  logic                  reset,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_vld,
  input  logic                  resp_rdy,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [31:0]           cpu_wdata,
  output logic                  cpu_wr,
  output logic                  cpu_rd,
  input  logic [31:0]           cpu_rdata
);

  typedef enum logic [1:0] {StIdle, StWr, StRdWait, StResp} state_e;

  localparam logic [3:0] RdLatCnt = 4'(RD_LAT);

  state_e                  state_q, state_d;
  logic                    req_rdy_q, req_rdy_d;
  logic                    resp_vld_q, resp_vld_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;
  logic [ADDR_WIDTH-1:0]   cpu_addr_q, cpu_addr_d;
  logic [31:0]             cpu_wdata_q, cpu_wdata_d;
  logic                    cpu_wr_q, cpu_wr_d;
  logic                    cpu_rd_q, cpu_rd_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    addr_bad;

`ifdef CPU_BUS_BRIDGE_ADDR_CHK_EN
  assign addr_bad = (req_addr > ADDR_MAX);
`else
  assign addr_bad = 1'b0;
  logic unused_addr_max;
  assign unused_addr_max = ^ADDR_MAX;
`endif

  always_comb begin
    state_d      = state_q;
    resp_vld_d   = resp_vld_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    cpu_addr_d   = cpu_addr_q;
    cpu_wdata_d  = cpu_wdata_q;
    cpu_wr_d     = 1'b0;
    cpu_rd_d     = cpu_rd_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (req_vld && req_rdy_q) begin
          cpu_addr_d  = req_addr;
          cpu_wdata_d = req_wdata;
          resp_err_d  = 1'b0;
          if (addr_bad) begin
            // Rejected address: skip the bus and answer on the next cycle.
            state_d      = StResp;
            resp_vld_d   = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'hDEAD_BEEF;
          end else if (req_wr) begin
            state_d  = StWr;
            cpu_wr_d = 1'b1;
          end else begin
            // Counter holds the number of the current RD_WAIT cycle, starting at 1.
            state_d  = StRdWait;
            cpu_rd_d = 1'b1;
            cnt_d    = 4'd1;
          end
        end
      end
      StWr: begin
        state_d      = StResp;
        resp_vld_d   = 1'b1;
        resp_rdata_d = '0;
      end
      StRdWait: begin
        if (cnt_q == RdLatCnt) begin
          state_d      = StResp;
          resp_vld_d   = 1'b1;
          resp_rdata_d = cpu_rdata;
          cpu_rd_d     = 1'b0;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        if (resp_rdy) begin
          state_d    = StIdle;
          resp_vld_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    req_rdy_d = (state_d == StIdle);
  end

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      req_rdy_q    <= 1'b1;
      resp_vld_q   <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      cpu_addr_q   <= '0;
      cpu_wdata_q  <= '0;
      cpu_wr_q     <= 1'b0;
      cpu_rd_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_rdy_q    <= req_rdy_d;
      resp_vld_q   <= resp_vld_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      cpu_addr_q   <= cpu_addr_d;
      cpu_wdata_q  <= cpu_wdata_d;
      cpu_wr_q     <= cpu_wr_d;
      cpu_rd_q     <= cpu_rd_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_rdy    = req_rdy_q;
  assign resp_vld   = resp_vld_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign cpu_addr   = cpu_addr_q;
  assign cpu_wdata  = cpu_wdata_q;
  assign cpu_wr     = cpu_wr_q;
  assign cpu_rd     = cpu_rd_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Testbench for cpu_bus_bridge. Four instances share one request bus, and each has its
// own req_vld:
//   0: RD_LAT = 2   main write/read/backpressure/reset tests
//   1: RD_LAT = 1   latency sweep
//   2: RD_LAT = 15  latency sweep
//   3: RD_LAT = 2, ADDR_MAX = 16'h00FF  address range check
// The bus model is a 256-word memory written by cpu_wr. Reads return the inverted
// stored word.
module tb_cpu_bus_bridge;

`ifdef CPU_BUS_BRIDGE_ADDR_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clks;
  logic        reset;
  logic [3:0]  req_vld;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_rdy;

  logic        req_rdy    [4];
  logic        resp_vld   [4];
  logic [31:0] resp_rdata [4];
  logic        resp_err   [4];
  logic [15:0] cpu_addr   [4];
  logic [31:0] cpu_wdata  [4];
  logic        cpu_wr     [4];
  logic        cpu_rd     [4];
  logic [31:0] cpu_rdata  [4];

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  initial clks = 1'b0;
  always #5 clks = ~clks;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cpu_bus_bridge #(
      .ADDR_WIDTH (16),
      .RD_LAT     ((g == 1) ? 1 : ((g == 2) ? 15 : 2)),
      .ADDR_MAX   ((g == 3) ? 16'h00FF : 16'hFFFF)
    ) u_dut (
      .clks       (clks),
      .reset      (reset),
      .req_vld    (req_vld[g]),
      .req_rdy    (req_rdy[g]),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_vld   (resp_vld[g]),
      .resp_rdy   (resp_rdy),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g]),
      .cpu_addr   (cpu_addr[g]),
      .cpu_wdata  (cpu_wdata[g]),
      .cpu_wr     (cpu_wr[g]),
      .cpu_rd     (cpu_rd[g]),
      .cpu_rdata  (cpu_rdata[g])
    );
    assign cpu_rdata[g] = ~mem[cpu_addr[g][7:0]];
  end

  always @(posedge clks) begin
    for (int k = 0; k < 4; k++) begin
      if (cpu_wr[k]) mem[cpu_addr[k][7:0]] <= cpu_wdata[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input int i);
    chk("rst_req_rdy", 32'(req_rdy[i]), 32'd1);
    chk("rst_resp_vld", 32'(resp_vld[i]), 32'd0);
    chk("rst_cpu_wr", 32'(cpu_wr[i]), 32'd0);
    chk("rst_cpu_rd", 32'(cpu_rd[i]), 32'd0);
    chk("rst_cpu_addr", 32'(cpu_addr[i]), 32'd0);
    chk("rst_cpu_wdata", cpu_wdata[i], 32'd0);
    chk("rst_resp_rdata", resp_rdata[i], 32'd0);
    chk("rst_resp_err", 32'(resp_err[i]), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; accept happens at the next posedge (edge N).
  task automatic do_write(input int i, input logic [15:0] a, input logic [31:0] d);
    req_vld[i] = 1'b1;
    req_wr     = 1'b1;
    req_addr   = a;
    req_wdata  = d;
    resp_rdy   = 1'b1;
    @(negedge clks);  // cycle N+1
    req_vld[i] = 1'b0;
    chk("wr_strobe", 32'(cpu_wr[i]), 32'd1);
    chk("wr_addr", 32'(cpu_addr[i]), 32'(a));
    chk("wr_wdata", cpu_wdata[i], d);
    chk("wr_busy_rdy", 32'(req_rdy[i]), 32'd0);
    chk("wr_no_early_resp", 32'(resp_vld[i]), 32'd0);
    @(negedge clks);  // cycle N+2
    chk("wr_strobe_end", 32'(cpu_wr[i]), 32'd0);
    chk("wr_resp_vld", 32'(resp_vld[i]), 32'd1);
    chk("wr_resp_rdata", resp_rdata[i], 32'd0);
    chk("wr_resp_err", 32'(resp_err[i]), 32'd0);
    @(negedge clks);  // response taken at end of N+2
    chk("wr_resp_drop", 32'(resp_vld[i]), 32'd0);
    chk("wr_rdy_back", 32'(req_rdy[i]), 32'd1);
  endtask

  // exp_lat: cycles from accept edge N to the first cycle with resp_vld.
  // hold: number of RESP cycles with resp_rdy low (0 = ready already on the first).
  task automatic do_read(input int i, input logic [15:0] a, input logic [31:0] exp_d,
                         input int exp_lat, input bit exp_err, input int hold);
    int lat;
    lat        = 0;
    req_vld[i] = 1'b1;
    req_wr     = 1'b0;
    req_addr   = a;
    resp_rdy   = (hold == 0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clks);
      if (c == 1) begin
        req_vld[i] = 1'b0;
        chk("rd_addr", 32'(cpu_addr[i]), 32'(a));
      end
      if (resp_vld[i]) begin
        lat = c;
        break;
      end
      chk("rd_cpu_rd", 32'(cpu_rd[i]), 32'd1);
      chk("rd_no_wr", 32'(cpu_wr[i]), 32'd0);
      chk("rd_busy_rdy", 32'(req_rdy[i]), 32'd0);
    end
    chk("rd_latency", 32'(lat), 32'(exp_lat));
    chk("rd_resp_rdata", resp_rdata[i], exp_d);
    chk("rd_resp_err", 32'(resp_err[i]), 32'(exp_err));
    chk("rd_cpu_rd_off", 32'(cpu_rd[i]), 32'd0);
    chk("rd_resp_no_wr", 32'(cpu_wr[i]), 32'd0);
    chk("rd_resp_busy", 32'(req_rdy[i]), 32'd0);
    for (int h = 1; h < hold; h++) begin
      @(negedge clks);
      chk("bp_vld_hold", 32'(resp_vld[i]), 32'd1);
      chk("bp_rdata_hold", resp_rdata[i], exp_d);
      chk("bp_err_hold", 32'(resp_err[i]), 32'(exp_err));
      chk("bp_busy", 32'(req_rdy[i]), 32'd0);
    end
    resp_rdy = 1'b1;
    @(negedge clks);
    chk("rd_resp_drop", 32'(resp_vld[i]), 32'd0);
    chk("rd_rdy_back", 32'(req_rdy[i]), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    req_vld   = '0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    resp_rdy  = 1'b1;
    repeat (3) @(negedge clks);
    for (int i = 0; i < 4; i++) chk_reset_state(i);
    reset = 1'b0;
    @(negedge clks);
    for (int i = 0; i < 4; i++) chk_reset_state(i);

    // Write, then read back the inverted word.
    do_write(0, 16'h0010, 32'h1234_5678);
    do_read(0, 16'h0010, 32'hEDCB_A987, 3, 1'b0, 0);
    // Response backpressure for 5 cycles.
    do_read(0, 16'h0010, 32'hEDCB_A987, 3, 1'b0, 5);

    // Reset in the middle of RD_WAIT.
    req_vld[0] = 1'b1;
    req_wr     = 1'b0;
    req_addr   = 16'h0010;
    resp_rdy   = 1'b1;
    @(negedge clks);
    req_vld[0] = 1'b0;
    chk("mid_rd_active", 32'(cpu_rd[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_state(0);
    @(negedge clks);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clks);
      chk("post_rst_no_resp", 32'(resp_vld[0]), 32'd0);
      chk("post_rst_idle", 32'(req_rdy[0]), 32'd1);
    end
    do_write(0, 16'h0020, 32'hCAFE_F00D);
    do_read(0, 16'h0020, 32'h3501_0FF2, 3, 1'b0, 0);

    // Latency sweep.
    do_read(1, 16'h0010, 32'hEDCB_A987, 2, 1'b0, 0);
    do_read(2, 16'h0010, 32'hEDCB_A987, 16, 1'b0, 0);

    // Address range check on the instance with ADDR_MAX = 0x00FF.
    do_write(0, 16'h00FF, 32'hA5A5_0000);
    do_write(0, 16'h0000, 32'h0F0F_0F0F);
    do_read(3, 16'h0100, ChkEn ? 32'hDEAD_BEEF : 32'hF0F0_F0F0, ChkEn ? 1 : 3, ChkEn, 0);
    do_read(3, 16'h00FF, 32'h5A5A_FFFF, 3, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
